// File: rtl/rgb_seq_pkg.sv
// Shared types and defaults for the RGB LED fade sequencer.
package rgb_seq_pkg;

  localparam int PWM_BITS_DEF = 8;
  localparam int STEP_W_DEF   = 16;
  localparam int PRESCALE_DEF = 188;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One colour at the default duty width, handy for packing commands upstream.
  typedef struct packed {
    logic [PWM_BITS_DEF-1:0] r;
    logic [PWM_BITS_DEF-1:0] g;
    logic [PWM_BITS_DEF-1:0] b;
  } rgb_duty_t;

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel: target/current/active duty, the +-1 ramp and the PWM
// compare register. The active duty only follows the current duty at a
// period boundary so a running PWM period is never cut short or stretched.
module rgb_fade_channel
  import rgb_seq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,       // latch a new target
  input  logic                imm_i,        // with load_i: jump straight to it
  input  logic                step_i,       // move one count toward target
  input  logic                period_end_i,
  input  logic [PWM_BITS-1:0] tgt_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                pwm_o,
  output logic                at_target_o
);

  logic [PWM_BITS-1:0] tgt_q, cur_q, cur_d, active_q;
  logic                pwm_q;

  // Next current duty: immediate load, or one step bounded by the target.
  always_comb begin
    cur_d = cur_q;
    if (load_i && imm_i) begin
      cur_d = tgt_i;
    end else if (step_i) begin
      if (cur_q < tgt_q)      cur_d = cur_q + 1'b1;
      else if (cur_q > tgt_q) cur_d = cur_q - 1'b1;
    end
  end

  // Duty registers and the registered PWM compare.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt_q    <= '0;
      cur_q    <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (load_i) tgt_q <= tgt_i;
      cur_q <= cur_d;
      if (period_end_i) active_q <= cur_q;
      pwm_q <= (pwm_cnt_i < active_q);
    end
  end

  assign pwm_o       = pwm_q;
  assign at_target_o = (cur_q == tgt_q);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// RGB LED driver front end: prescaled PWM timebase, command handshake and
// the jump/fade state machine feeding three fade channels.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [PWM_BITS-1:0] cmd_r_i,
  input  logic [PWM_BITS-1:0] cmd_g_i,
  input  logic [PWM_BITS-1:0] cmd_b_i,
  input  logic [STEP_W-1:0]   cmd_step_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pwm_r_o,
  output logic                pwm_g_o,
  output logic                pwm_b_o,
  output logic                led_en_o
);

  localparam int               PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]    pre_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                tick, period_end;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d, step_per_q, step_per_d;
  logic                cmd_ready_q, busy_q, done_q, led_en_q;
  logic                accept, load, imm, step_en, all_at;

  logic [2:0][PWM_BITS-1:0] tgt_in;
  logic [2:0]               pwm, at_tgt;

  assign tick       = (pre_cnt_q == PRE_MAX);
  assign period_end = tick && (pwm_cnt_q == '1);

  // cmd_ready_q is only ever high while the FSM sits in IDLE.
  assign accept = cmd_valid_i && cmd_ready_q;
  assign all_at = &at_tgt;

  // Free-running prescaler and PWM counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pre_cnt_q <= tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  // Command/fade sequencing: next state, step pacing and channel strobes.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    step_per_d = step_per_q;
    load       = 1'b0;
    imm        = 1'b0;
    step_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load       = 1'b1;
          step_per_d = cmd_step_i;
          step_cnt_d = '0;
          if (cmd_step_i == '0) begin
            imm     = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_FADE;
          end
        end
      end
      ST_FADE: begin
        if (all_at) begin
          state_d = ST_DONE;
        end else if (period_end) begin
          if (step_cnt_q == step_per_q - 1'b1) begin
            step_cnt_d = '0;
            step_en    = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered status outputs. ready/busy track the state
  // being entered; done follows one cycle behind the DONE state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      step_cnt_q  <= '0;
      step_per_q  <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      led_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      step_per_q  <= step_per_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d == ST_FADE);
      done_q      <= (state_q == ST_DONE);
      led_en_q    <= 1'b1;
    end
  end

  assign tgt_in = {cmd_b_i, cmd_g_i, cmd_r_i};

  for (genvar c = 0; c < 3; c++) begin : g_ch
    rgb_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (load),
      .imm_i        (imm),
      .step_i       (step_en),
      .period_end_i (period_end),
      .tgt_i        (tgt_in[c]),
      .pwm_cnt_i    (pwm_cnt_q),
      .pwm_o        (pwm[c]),
      .at_target_o  (at_tgt[c])
    );
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pwm_r_o     = pwm[0];
  assign pwm_g_o     = pwm[1];
  assign pwm_b_o     = pwm[2];
  assign led_en_o    = led_en_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer (PRESCALE=2, PWM_BITS=4 -> 32 clk periods).
// Edge j after reset release: pre_cnt = j%2, pwm_cnt = (j/2)%16. The duty
// loaded at period edge 32p shows up as pwm samples after edges 32p+1..32p+32,
// i.e. 2*duty high samples. The reference model works per PWM period: a
// fade moves each channel one count toward its target every st period ends.
module tb_rgb_fade_sequencer;
  localparam int PB  = 4;
  localparam int PS  = 2;
  localparam int SW  = 16;
  localparam int PER = PS * (1 << PB);

  logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
  logic [PB-1:0] cmd_r = '0, cmd_g = '0, cmd_b = '0;
  logic [SW-1:0] cmd_step = '0;
  logic          cmd_ready, busy, done, pwm_r, pwm_g, pwm_b, led_en;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0;
  int ar = 0, ag = 0, ab = 0;
  int hr[4096], hg[4096], hb[4096];
  int model[3];

  typedef struct { int r, g, b, st, er, eg, eb; } vec_t;
  vec_t tbl[4];

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.PWM_BITS(PB), .PRESCALE(PS), .STEP_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_r_i(cmd_r), .cmd_g_i(cmd_g), .cmd_b_i(cmd_b), .cmd_step_i(cmd_step),
    .busy_o(busy), .done_o(done), .pwm_r_o(pwm_r), .pwm_g_o(pwm_g),
    .pwm_b_o(pwm_b), .led_en_o(led_en)
  );

  // Edge counter since reset release.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Per-period high-sample histogram and done pulse counter.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (rst) begin
      ar <= 0; ag <= 0; ab <= 0;
    end else if (cyc > 0) begin
      if (cyc % PER == 0) begin
        hr[cyc/PER-1] <= ar + (pwm_r ? 1 : 0);
        hg[cyc/PER-1] <= ag + (pwm_g ? 1 : 0);
        hb[cyc/PER-1] <= ab + (pwm_b ? 1 : 0);
        ar <= 0; ag <= 0; ab <= 0;
      end else begin
        ar <= ar + (pwm_r ? 1 : 0);
        ag <= ag + (pwm_g ? 1 : 0);
        ab <= ab + (pwm_b ? 1 : 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Colour of one channel after a given number of +-1 steps from s toward t.
  function automatic int ramp(input int s, input int t, input int steps);
    if (iabs(t - s) <= steps) return t;
    return (t > s) ? s + steps : s - steps;
  endfunction

  // Drive a command and hold it until accepted; a = edge that accepted it.
  task automatic send(input int r, input int g, input int b, input int st, output int a);
    int w;
    cmd_r = PB'(r); cmd_g = PB'(g); cmd_b = PB'(b); cmd_step = SW'(st);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 4000) begin step(); w++; end
    if (!cmd_ready) begin
      check("accept_wait", cmd_ready, 1);
      cmd_valid = 1'b0;
      a = -1;
      return;
    end
    step();
    a = cyc;
    cmd_valid = 1'b0;
  endtask

  // Issue one command and check done timing, busy span and every PWM period
  // from the first boundary after accept until the target is showing.
  task automatic run_cmd(input int r, input int g, input int b, input int st, output int last_idx);
    int tg[3];
    int md, n, a, d, dexp, e1, bc, dc0, kl, idx, steps;
    tg[0] = r; tg[1] = g; tg[2] = b;
    md = 0;
    for (int c = 0; c < 3; c++) if (iabs(tg[c] - model[c]) > md) md = iabs(tg[c] - model[c]);
    n = md * st;
    last_idx = 0;
    send(r, g, b, st, a);
    if (a < 0) return;
    dc0 = done_cnt; bc = 0; d = -1;
    for (int i = 0; i < PER*(n+3) + 64; i++) begin
      if (done) begin d = cyc; break; end
      bc += busy;
      step();
    end
    e1 = (a/PER + 1) * PER;
    if (st == 0)      dexp = a + 1;
    else if (n == 0)  dexp = a + 2;
    else              dexp = e1 + PER*(n-1) + 2;
    check("done_time", d, dexp);
    check("busy_cycles", bc, (st == 0) ? 0 : dexp - 1 - a);
    kl = (st == 0) ? 1 : n + 1;
    while (cyc <= e1 + PER*kl) step();
    check("done_once", done_cnt - dc0, 1);
    for (int k = 1; k <= kl; k++) begin
      idx   = (e1 + PER*(k-1)) / PER;
      steps = (st == 0) ? 0 : (k-1) / st;
      check("period_r", hr[idx], PS * ((st == 0) ? tg[0] : ramp(model[0], tg[0], steps)));
      check("period_g", hg[idx], PS * ((st == 0) ? tg[1] : ramp(model[1], tg[1], steps)));
      check("period_b", hb[idx], PS * ((st == 0) ? tg[2] : ramp(model[2], tg[2], steps)));
    end
    last_idx = (e1 + PER*(kl-1)) / PER;
    model = tg;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int li, a, d, d2, rdy, e, n, e1, dc0;
    // {r, g, b, step, expected high ticks per period r/g/b}
    tbl[0] = '{8, 0, 15, 0, 8, 0, 15};
    tbl[1] = '{15, 15, 15, 0, 15, 15, 15};
    tbl[2] = '{1, 14, 7, 0, 1, 14, 7};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 0};
    model = '{0, 0, 0};

    // Reset and idle.
    repeat (3) step();
    check("reset_outputs", {cmd_ready, busy, done, led_en, pwm_r, pwm_g, pwm_b}, 0);
    rst = 1'b0;
    step();
    check("idle_ready_led", {cmd_ready, led_en}, 2'b11);
    while (cyc <= 3*PER) step();
    check("idle_dark", hr[0]+hr[1]+hr[2]+hg[0]+hg[1]+hg[2]+hb[0]+hb[1]+hb[2], 0);

    // Immediate jumps from the table.
    for (int i = 0; i < 4; i++) begin
      run_cmd(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].st, li);
      check("tbl_r", hr[li], PS * tbl[i].er);
      check("tbl_g", hg[li], PS * tbl[i].eg);
      check("tbl_b", hb[li], PS * tbl[i].eb);
    end

    // Fade up from black, fade down at step 3, then a no-change fade.
    run_cmd(4, 2, 0, 1, li);
    run_cmd(1, 2, 0, 3, li);
    run_cmd(1, 2, 0, 2, li);

    // Handshake: a command held during a fade is ignored, then taken on
    // the first IDLE cycle.
    send(15, 15, 15, 2, a);
    n  = 15 * 2;
    e1 = (a/PER + 1) * PER;
    repeat (40) step();
    cmd_r = '0; cmd_g = '0; cmd_b = '0; cmd_step = '0;
    cmd_valid = 1'b1;
    rdy = 0; d = -1;
    for (int i = 0; i < PER*(n+3); i++) begin
      if (done) begin d = cyc; break; end
      rdy += cmd_ready;
      step();
    end
    check("held_ignored", d, e1 + PER*(n-1) + 2);
    check("held_ready_low", rdy, 0);
    d2 = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) begin d2 = cyc; break; end
    end
    check("held_accept", d2, d + 2);
    cmd_valid = 1'b0;
    model = '{0, 0, 0};
    e = ((d + 1)/PER + 1) * PER;
    while (cyc <= e + PER) step();
    check("held_colour", hr[e/PER] + hg[e/PER] + hb[e/PER], 0);

    // Randomised commands against the period-level model.
    for (int i = 0; i < 6; i++)
      run_cmd($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 2), li);

    // Reset in the middle of a fade.
    send(15 - model[0], 15 - model[1], 15 - model[2], 1, a);
    repeat (100) step();
    check("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    check("mid_rst_outputs", {cmd_ready, busy, done, led_en, pwm_r, pwm_g, pwm_b}, 0);
    step();
    rst = 1'b0;
    model = '{0, 0, 0};
    dc0 = done_cnt;
    step();
    check("mid_rst_idle", {cmd_ready, busy, led_en}, 3'b101);
    while (cyc <= 2*PER) step();
    check("mid_rst_dark", hr[0]+hr[1]+hg[0]+hg[1]+hb[0]+hb[1], 0);
    check("mid_rst_no_done", done_cnt - dc0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Controller for the on-chip RGB LED driver. Generates the three PWM inputs (RGB0PWM/RGB1PWM/RGB2PWM) and the LED enable from one free-running PWM timebase.
- Accepts colour commands over a valid/ready interface. Each command either jumps to a target colour or fades linearly to it.
- Sits between the system logic and the SB_RGBA_DRV primitive, in the 48 MHz HFOSC domain.

Parameters:
- PWM_BITS, 8: duty and PWM counter width; one PWM period is 2^PWM_BITS ticks.
- PRESCALE, 188: clk cycles per PWM tick. 48 MHz / 188 / 256 ≈ 1 kHz PWM. Legal range is ≥1.
- STEP_W, 16: width of the fade step-period field.

Ports:
- clk  in  1  system clock (HFOSC output).
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_r  in  PWM_BITS  target red duty.
- cmd_g  in  PWM_BITS  target green duty.
- cmd_b  in  PWM_BITS  target blue duty.
- cmd_step  in  STEP_W  PWM periods per ±1 duty step; 0 = immediate.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the target colour is reached.
- pwm_r  out  1  to RGB0PWM.
- pwm_g  out  1  to RGB1PWM.
- pwm_b  out  1  to RGB2PWM.
- led_en  out  1  to RGBLEDEN.

Behaviour:
- Reset values (rst high at a clk edge): all counters, cur/active duties, pwm_* = 0; done = 0; busy = 0; led_en = 0; cmd_ready = 0; state = IDLE. rst has priority over every other event, including mid-fade; any fade in progress is discarded.
- Outside reset: led_en = 1 (registered).
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. tick = (pre_cnt == PRESCALE-1).
- PWM counter: pwm_cnt increments on tick, wrapping from 2^PWM_BITS-1 to 0. period_end = tick && pwm_cnt == 2^PWM_BITS-1.
- PWM outputs: pwm_x registered as (pwm_cnt < active_x).
  - Duty 0 gives constant low.
  - Duty 2^PWM_BITS-1 gives high for all but one tick per period.
  - Output latency is 1 clk from the counter.
- Glitch-free duty update: active_x <= cur_x only on period_end. A duty change never truncates or extends a period already in progress.
- State machine:
  - IDLE: cmd_ready = 1.
    - On cmd_valid: latch tgt_r/g/b and step_per.
    - If cmd_step == 0: cur_x <= tgt_x and go to DONE.
    - Otherwise clear step_cnt and go to FADE.
  - FADE: busy = 1, cmd_ready = 0.
    - step_cnt increments on period_end.
    - When step_cnt == step_per-1 and period_end: clear step_cnt, and each cur_x moves one toward tgt_x (+1 if below, −1 if above, unchanged if equal).
    - Channels move independently; each stops at its own target.
    - When all cur_x == tgt_x (checked every cycle, using the registered values), go to DONE.
    - A command whose target equals the current colour reaches DONE on the cycle after FADE is entered.
  - DONE: done = 1 for exactly one cycle; busy = 0; cmd_ready = 0. Next state IDLE.
- cmd_valid while cmd_ready = 0 is ignored. Commands are not queued; the source must hold valid until it sees ready.
- Fade duration is max_x(|tgt_x − cur_x|) × step_per PWM periods, ±1 period of alignment.
- Arithmetic: cur_x never wraps; ±1 steps are bounded by tgt_x. step_cnt is STEP_W wide and compared against step_per-1.

Decomposition:
- Package rgb_seq_pkg:
  - state enum {IDLE, FADE, DONE};
  - PWM_BITS and STEP_W defaults;
  - a packed rgb_duty_t struct {r, g, b}.
- Sub-module rgb_fade_channel, instantiated ×3. Holds cur/tgt/active duty, the ±1 ramp logic, the compare and the pwm register, and exports at_target.
- The top level owns the prescaler, pwm_cnt, step_cnt, the FSM and the handshake.

Test Plan (bench uses PRESCALE=2, PWM_BITS=4):
- Reset then idle:
  - All outputs 0 during rst.
  - After release: cmd_ready = 1, led_en = 1, and pwm_* stay 0 over 3 periods.
- Immediate command (cmd r=8, g=0, b=15, step=0):
  - done pulses 2 cycles after accept.
  - From the next period_end: pwm_r is high 8 of 16 ticks, pwm_g is never high, pwm_b is high 15 of 16 ticks.
- Fade up (from 0, cmd r=4, g=2, b=0, step=1):
  - cur_r reaches 4 after 4 period_ends; cur_g stops at 2 after 2.
  - done fires once; busy is high throughout.
- Fade down with step=3 (from r=4, cmd r=1):
  - cur_r decrements every 3rd period_end.
  - done after 9 periods ±1.
- Handshake:
  - cmd_valid held during FADE → no accept and no change to the targets.
  - Valid still held in IDLE → accepted on the first IDLE cycle.
- Reset mid-fade:
  - rst asserted in FADE → next cycle all duties and pwm_* = 0, state IDLE, no done pulse.
